split_mem_responder: RTL and testbench
======================================

Name: split_mem_responder

Overview:
- Responder side of the CPU's split instruction/data memory interface.
- Accepts instruction fetches (instruction_request/instruction_address) and data accesses (data_request/mem_address/write_enable/mem_byte_enable/write_data) from the pipelined datapath.
- Arbitrates them onto one multi-cycle physical memory port and returns instr/mem_rdata with one-cycle response pulses.
- Sits between cpu_datapath and the cache/physical memory.

Parameters:
- ADDR_W, 16, width of CPU and physical addresses.
- DATA_W, 16, width of data words.
- TIMEOUT, 255, maximum cycles to wait for pmem_resp before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- instruction_request  in  1  fetch request, level, held by CPU until response
- instruction_address  in  ADDR_W  fetch address
- instruction_response  out  1  one-cycle pulse: instr valid
- instr  out  DATA_W  fetched word
- data_request  in  1  data request, level, held until response
- mem_address  in  ADDR_W  data address
- write_enable  in  1  1=store, 0=load
- mem_byte_enable  in  2  store byte lanes [1]=high byte, [0]=low byte
- write_data  in  DATA_W  store data
- data_response  out  1  one-cycle pulse: data access done
- mem_rdata  out  DATA_W  load data
- pmem_read  out  1  physical read strobe, level
- pmem_write  out  1  physical write strobe, level
- pmem_address  out  ADDR_W  physical address
- pmem_wdata  out  DATA_W  physical write data
- pmem_byte_enable  out  2  physical byte lanes
- pmem_rdata  in  DATA_W  physical read data, valid with pmem_resp
- pmem_resp  in  1  physical access complete, one cycle
- err_timeout  out  1  sticky watchdog error flag

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; all outputs 0; watchdog counter 0; err_timeout cleared.
  - pmem strobes drop immediately; any in-flight access is abandoned with no response.
- States: IDLE, I_ACC, D_ACC, RESP.
- IDLE:
  - data_request=1 wins over instruction_request=1 (data is the older pipeline stage). Latch address, write_enable, byte enable and write data, then go to D_ACC.
  - Otherwise, if instruction_request=1, latch instruction_address and go to I_ACC.
  - Granted request is sampled at the IDLE clock edge; pmem strobe is asserted from the next cycle.
- D_ACC / I_ACC:
  - Drive the latched address.
  - Read: pmem_read=1, pmem_byte_enable=2'b11.
  - Store: pmem_write=1, pmem_wdata=latched data, pmem_byte_enable=latched value.
  - I_ACC is always a read.
  - Strobes are held until pmem_resp.
  - On pmem_resp: register pmem_rdata into instr (I_ACC) or mem_rdata (D_ACC load), drop strobes, go to RESP.
  - Store leaves mem_rdata unchanged.
- Store with mem_byte_enable=2'b00: no pmem access; go IDLE→RESP directly (no-op completion).
- RESP:
  - One-cycle pulse on instruction_response or data_response, whichever was granted.
  - instr/mem_rdata hold their value until the next completion of the same kind.
  - Return to IDLE.
  - Minimum latency, request seen in IDLE to response: pmem latency + 2 cycles.
- Back-to-back: a request still high in the cycle after its response is treated as a new request. The CPU must drop or change it on the response edge.
- Requests dropped mid-access: the access still completes and the response still pulses.
- The unrelated requester waits; its request is held and served after RESP→IDLE.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to *_ACC and increments each *_ACC cycle without pmem_resp.
  - At count==TIMEOUT: drop strobes, set err_timeout=1 (sticky), go to RESP.
  - Returned word for an aborted read = 16'h0000.
  - If pmem_resp arrives in the same cycle the count reaches TIMEOUT, pmem_resp wins and there is no error.
- pmem_resp outside *_ACC is ignored.
- Exactly one pmem strobe is asserted at any time; never both.

Test Plan:
- Single fetch: instruction_request=1, addr 16'h0040; pmem_resp after 3 cycles with 16'h1234 -> pmem_read high 3 cycles at 16'h0040; instruction_response one pulse; instr=16'h1234; latency 5.
- Simultaneous requests: fetch 16'h0010 and load 16'h2000 in the same IDLE cycle -> load served first, data_response pulses; then fetch served; instruction_response pulses after; no overlap of strobes.
- Byte store: write_enable=1, mem_byte_enable=2'b10, addr 16'h3001, data 16'hAB00 -> pmem_write with byte enable 2'b10, pmem_wdata 16'hAB00; mem_rdata unchanged; one data_response.
- Zero-lane store: mem_byte_enable=2'b00 -> no pmem strobe; data_response 2 cycles after request.
- Timeout: TIMEOUT=8, pmem_resp never asserted -> pmem_read high exactly 8 cycles; err_timeout=1 and stays 1; response pulses with 16'h0000; next request is served normally.
- Reset mid-access: rst_n low during D_ACC -> pmem_write drops asynchronously; no data_response; after release FSM is IDLE and a new fetch completes normally.

Source files
------------

// File: rtl/split_mem_responder.sv
// Responder for the CPU's split instruction/data memory interface: arbitrates
// fetches and data accesses onto one multi-cycle physical port, with a watchdog.
module split_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instruction_request,
  input  logic [ADDR_W-1:0] instruction_address,
  output logic              instruction_response,
  output logic [DATA_W-1:0] instr,
  input  logic              data_request,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              write_enable,
  input  logic [1:0]        mem_byte_enable,
  input  logic [DATA_W-1:0] write_data,
  output logic              data_response,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [1:0]        pmem_byte_enable,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gnt_data_q, gnt_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic in_acc;
  logic timeout_hit;

  assign in_acc = (state_q == I_ACC) || (state_q == D_ACC);

  // The cycle the count would reach TIMEOUT; a same-cycle pmem_resp wins.
  assign timeout_hit = (TIMEOUT != 0) && in_acc && !pmem_resp &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    gnt_data_d = gnt_data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (data_request) begin
          addr_d     = mem_address;
          we_d       = write_enable;
          be_d       = mem_byte_enable;
          wdata_d    = write_data;
          gnt_data_d = 1'b1;
          cnt_d      = '0;
          // A store with no lanes enabled completes without touching pmem.
          state_d    = (write_enable && mem_byte_enable == 2'b00) ? RESP : D_ACC;
        end else if (instruction_request) begin
          addr_d     = instruction_address;
          we_d       = 1'b0;
          be_d       = 2'b11;
          gnt_data_d = 1'b0;
          cnt_d      = '0;
          state_d    = I_ACC;
        end
      end
      I_ACC, D_ACC: begin
        if (pmem_resp) begin
          state_d = RESP;
          if (state_q == I_ACC) instr_d = pmem_rdata;
          else if (!we_q)       rdata_d = pmem_rdata;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (state_q == I_ACC) instr_d = '0;
          else if (!we_q)       rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 2'b00;
      wdata_q    <= '0;
      gnt_data_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      instr_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      gnt_data_q <= gnt_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Strobes decode straight from state so reset drops them asynchronously.
  assign pmem_read        = (state_q == I_ACC) || ((state_q == D_ACC) && !we_q);
  assign pmem_write       = (state_q == D_ACC) && we_q;
  assign pmem_address     = in_acc ? addr_q : '0;
  assign pmem_wdata       = pmem_write ? wdata_q : '0;
  assign pmem_byte_enable = pmem_read ? 2'b11 : (pmem_write ? be_q : 2'b00);

  assign instruction_response = (state_q == RESP) && !gnt_data_q;
  assign data_response        = (state_q == RESP) && gnt_data_q;
  assign instr                = instr_q;
  assign mem_rdata            = rdata_q;
  assign err_timeout          = err_q;

endmodule

// File: tb/tb_split_mem_responder.sv
// Directed bench for split_mem_responder with a small pmem model driving
// pmem_resp a programmable number of strobe cycles after the access starts.
module tb_split_mem_responder;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          instruction_request;
  logic [AW-1:0] instruction_address;
  logic          instruction_response;
  logic [DW-1:0] instr;
  logic          data_request;
  logic [AW-1:0] mem_address;
  logic          write_enable;
  logic [1:0]    mem_byte_enable;
  logic [DW-1:0] write_data;
  logic          data_response;
  logic [DW-1:0] mem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [DW-1:0] pmem_wdata;
  logic [1:0]    pmem_byte_enable;
  logic [DW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          err_timeout;

  split_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instruction_request(instruction_request), .instruction_address(instruction_address),
    .instruction_response(instruction_response), .instr(instr),
    .data_request(data_request), .mem_address(mem_address),
    .write_enable(write_enable), .mem_byte_enable(mem_byte_enable),
    .write_data(write_data), .data_response(data_response), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int pm_lat = 3;
  bit pm_hang = 1'b0;
  int pm_cnt = 0;
  int rd_cycles = 0, wr_cycles = 0, both_cnt = 0, i_cnt = 0, d_cnt = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic [1:0]    last_be;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 16'h0040) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // pmem model and activity monitor, evaluated mid-cycle
  always @(negedge clk) begin
    if (pmem_read && pmem_write) both_cnt++;
    if (pmem_read)  rd_cycles++;
    if (pmem_write) wr_cycles++;
    if (instruction_response) i_cnt++;
    if (data_response)        d_cnt++;
    if (pmem_read || pmem_write) begin
      pm_cnt++;
      last_addr  = pmem_address;
      last_wdata = pmem_wdata;
      last_be    = pmem_byte_enable;
      if (!pm_hang && pm_cnt == pm_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_word(pmem_address);
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
      end
    end else begin
      pm_cnt     = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
    end
  end

  // Latency counts edges from the sampling edge through the edge that
  // captures the response; returns at negedge+1 with the response visible.
  task automatic wait_resp(input bit want_data, input int bound, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      lat = i + 1;
      @(negedge clk);
      #1;
      if (want_data ? data_response : instruction_response) begin
        ok  = 1'b1;
        lat = lat + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instruction_request = 1'b0; instruction_address = '0;
    data_request = 1'b0; mem_address = '0; write_enable = 1'b0;
    mem_byte_enable = 2'b00; write_data = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({pmem_read, pmem_write, instruction_response, data_response, err_timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: rd/wr/iresp/dresp/err=%b want 00000",
               {pmem_read, pmem_write, instruction_response, data_response, err_timeout});
    end
    vectors++;
    if ({instr, mem_rdata, pmem_address, pmem_wdata, pmem_byte_enable} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: instr=%h rdata=%h addr=%h wdata=%h be=%b want all 0",
               instr, mem_rdata, pmem_address, pmem_wdata, pmem_byte_enable);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    int lat; bit ok; int rd0, i0;
    pm_lat = 3; rd0 = rd_cycles; i0 = i_cnt;
    @(negedge clk); #1;
    instruction_address = 16'h0040; instruction_request = 1'b1;
    wait_resp(1'b0, 20, lat, ok);
    instruction_request = 1'b0;
    vectors++;
    if (!ok || lat != 5) begin
      miscompares++;
      $display("FAIL fetch_latency: got=%0d seen=%0d want 5", lat, ok);
    end
    vectors++;
    if (instr !== 16'h1234) begin
      miscompares++;
      $display("FAIL fetch_instr: got=%h want 1234", instr);
    end
    vectors++;
    if (last_addr !== 16'h0040 || last_be !== 2'b11) begin
      miscompares++;
      $display("FAIL fetch_addr: addr=%h be=%b want 0040 11", last_addr, last_be);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (rd_cycles - rd0 != 3 || i_cnt - i0 != 1) begin
      miscompares++;
      $display("FAIL fetch_counts: rd=%0d pulses=%0d want 3 1", rd_cycles - rd0, i_cnt - i0);
    end
  endtask

  task automatic test_simultaneous();
    int lat; bit ok; int i0, d0, rd0;
    pm_lat = 2; i0 = i_cnt; d0 = d_cnt; rd0 = rd_cycles;
    @(negedge clk); #1;
    instruction_address = 16'h0010; instruction_request = 1'b1;
    mem_address = 16'h2000; write_enable = 1'b0; mem_byte_enable = 2'b11; data_request = 1'b1;
    wait_resp(1'b1, 20, lat, ok);
    data_request = 1'b0;
    vectors++;
    if (!ok || i_cnt != i0 || mem_rdata !== 16'h7A5A) begin
      miscompares++;
      $display("FAIL simul_data_first: seen=%0d ipulses=%0d rdata=%h want 1 0 7a5a",
               ok, i_cnt - i0, mem_rdata);
    end
    wait_resp(1'b0, 20, lat, ok);
    instruction_request = 1'b0;
    vectors++;
    if (!ok || instr !== 16'h5A4A) begin
      miscompares++;
      $display("FAIL simul_fetch: seen=%0d instr=%h want 1 5a4a", ok, instr);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (i_cnt - i0 != 1 || d_cnt - d0 != 1 || rd_cycles - rd0 != 4) begin
      miscompares++;
      $display("FAIL simul_counts: i=%0d d=%0d rd=%0d want 1 1 4",
               i_cnt - i0, d_cnt - d0, rd_cycles - rd0);
    end
  endtask

  task automatic test_byte_store();
    int lat; bit ok; int d0, wr0, rd0;
    pm_lat = 2; d0 = d_cnt; wr0 = wr_cycles; rd0 = rd_cycles;
    @(negedge clk); #1;
    mem_address = 16'h3001; write_enable = 1'b1; mem_byte_enable = 2'b10;
    write_data = 16'hAB00; data_request = 1'b1;
    wait_resp(1'b1, 20, lat, ok);
    data_request = 1'b0;
    vectors++;
    if (!ok || last_addr !== 16'h3001 || last_be !== 2'b10 || last_wdata !== 16'hAB00) begin
      miscompares++;
      $display("FAIL store_bus: seen=%0d addr=%h be=%b wdata=%h want 1 3001 10 ab00",
               ok, last_addr, last_be, last_wdata);
    end
    vectors++;
    if (mem_rdata !== 16'h7A5A) begin
      miscompares++;
      $display("FAIL store_rdata_kept: got=%h want 7a5a", mem_rdata);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (wr_cycles - wr0 != 2 || rd_cycles != rd0 || d_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL store_counts: wr=%0d rd=%0d d=%0d want 2 0 1",
               wr_cycles - wr0, rd_cycles - rd0, d_cnt - d0);
    end
  endtask

  task automatic test_zero_lane();
    int lat; bit ok; int d0, wr0, rd0;
    d0 = d_cnt; wr0 = wr_cycles; rd0 = rd_cycles;
    @(negedge clk); #1;
    mem_address = 16'h3002; write_enable = 1'b1; mem_byte_enable = 2'b00;
    write_data = 16'h00FF; data_request = 1'b1;
    wait_resp(1'b1, 20, lat, ok);
    data_request = 1'b0; write_enable = 1'b0;
    vectors++;
    if (!ok || lat != 2) begin
      miscompares++;
      $display("FAIL zero_lane_latency: got=%0d seen=%0d want 2", lat, ok);
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (wr_cycles != wr0 || rd_cycles != rd0 || d_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL zero_lane_counts: wr=%0d rd=%0d d=%0d want 0 0 1",
               wr_cycles - wr0, rd_cycles - rd0, d_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok1, ok2; int i0, rd0;
    pm_lat = 1; i0 = i_cnt; rd0 = rd_cycles;
    @(negedge clk); #1;
    instruction_address = 16'h0080; instruction_request = 1'b1;
    wait_resp(1'b0, 20, lat, ok1);
    wait_resp(1'b0, 20, lat, ok2);
    instruction_request = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (!ok1 || !ok2 || i_cnt - i0 != 2 || rd_cycles - rd0 != 2 || instr !== 16'h5ADA) begin
      miscompares++;
      $display("FAIL back_to_back: seen=%0d%0d pulses=%0d rd=%0d instr=%h want 11 2 2 5ada",
               ok1, ok2, i_cnt - i0, rd_cycles - rd0, instr);
    end
  endtask

  task automatic test_timeout();
    int lat; bit ok; int rd0;
    pm_hang = 1'b1; rd0 = rd_cycles;
    @(negedge clk); #1;
    instruction_address = 16'h0050; instruction_request = 1'b1;
    wait_resp(1'b0, 30, lat, ok);
    instruction_request = 1'b0;
    vectors++;
    if (!ok || lat != 10 || rd_cycles - rd0 != 8) begin
      miscompares++;
      $display("FAIL timeout_len: seen=%0d lat=%0d rd=%0d want 1 10 8", ok, lat, rd_cycles - rd0);
    end
    vectors++;
    if (instr !== 16'h0000 || err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_result: instr=%h err=%b want 0000 1", instr, err_timeout);
    end
    pm_hang = 1'b0; pm_lat = 1;
    @(negedge clk); #1;
    instruction_address = 16'h0040; instruction_request = 1'b1;
    wait_resp(1'b0, 20, lat, ok);
    instruction_request = 1'b0;
    vectors++;
    if (!ok || lat != 3 || instr !== 16'h1234 || err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_recover: seen=%0d lat=%0d instr=%h err=%b want 1 3 1234 1",
               ok, lat, instr, err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; bit seen; int d0;
    pm_hang = 1'b1; seen = 1'b0;
    @(negedge clk); #1;
    d0 = d_cnt;
    mem_address = 16'h4000; write_enable = 1'b1; mem_byte_enable = 2'b11;
    write_data = 16'hBEEF; data_request = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      seen = pmem_write;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!seen || pmem_write !== 1'b0 || pmem_byte_enable !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_drop: started=%0d wr=%b be=%b want 1 0 00",
               seen, pmem_write, pmem_byte_enable);
    end
    repeat (2) @(negedge clk);
    #1;
    data_request = 1'b0; write_enable = 1'b0;
    rst_n = 1'b1;
    pm_hang = 1'b0; pm_lat = 2;
    vectors++;
    if (d_cnt != d0 || err_timeout !== 1'b0 || instr !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid_state: dpulses=%0d err=%b instr=%h want 0 0 0000",
               d_cnt - d0, err_timeout, instr);
    end
    @(negedge clk); #1;
    instruction_address = 16'h0080; instruction_request = 1'b1;
    wait_resp(1'b0, 20, lat, ok);
    instruction_request = 1'b0;
    vectors++;
    if (!ok || lat != 4 || instr !== 16'h5ADA || d_cnt != d0) begin
      miscompares++;
      $display("FAIL reset_mid_fetch: seen=%0d lat=%0d instr=%h dpulses=%0d want 1 4 5ada 0",
               ok, lat, instr, d_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_byte_store();
    test_zero_lane();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    vectors++;
    if (both_cnt != 0) begin
      miscompares++;
      $display("FAIL strobe_exclusive: both-high cycles=%0d want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
